// File: rtl/cone_eval_if.sv
// Request/response bundle for the shared timing-cone scheduler.
// The scheduler takes the slave view; requesters and the result consumer take the master view.
interface cone_eval_if #(
    parameter int N   = 4,
    parameter int IDW = 2
);
    logic [N-1:0]   req_valid;
    logic [3*N-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [IDW-1:0] rsp_id;
    logic           rsp_data;

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/cone_eval_sched.sv
// Time-shares one external 3-input combinational cone among N requesters.
// Round-robin grant, operands held for CONE_LAT cycles, cone_y sampled at the
// end of the last hold cycle and returned with the owner ID on a valid/ready channel.
module cone_eval_sched #(
    parameter int N        = 4,
    parameter int IDW      = 2,
    parameter int CONE_LAT = 2,
    parameter int CNTW     = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    cone_eval_if.slave      bus,
    output logic            cone_a,
    output logic            cone_b,
    output logic            cone_c,
    input  logic            cone_y,
    output logic            cone_en,
    output logic            busy,
    output logic [CNTW-1:0] done_cnt
);
    // Settle counter wide enough to hold CONE_LAT-1 (at least one bit).
    localparam int SW = (CONE_LAT > 1) ? $clog2(CONE_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [SW-1:0]   cnt_q, cnt_d;
    logic [2:0]      ops_q, ops_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic            rsp_data_q, rsp_data_d;
    logic [CNTW-1:0] done_cnt_q, done_cnt_d;
    logic            cone_en_q, cone_en_d;
    logic            busy_q, busy_d;

    logic            gnt_found_s;
    logic [IDW-1:0]  gnt_idx_s;
    logic [IDW-1:0]  scan_idx_s;
    logic            gnt_take_s;
    logic [N-1:0]    req_ready_s;

    // Round-robin search: first valid requester at or above rr_ptr, wrapping modulo N.
    always_comb begin
        gnt_found_s = 1'b0;
        gnt_idx_s   = '0;
        scan_idx_s  = '0;
        for (int k = 0; k < N; k++) begin
            scan_idx_s = IDW'((int'(rr_ptr_q) + k) % N);
            if (!gnt_found_s && bus.req_valid[scan_idx_s]) begin
                gnt_found_s = 1'b1;
                gnt_idx_s   = scan_idx_s;
            end else begin
                gnt_found_s = gnt_found_s;
            end
        end
    end

    // Next-state and datapath update for the IDLE/SETTLE/RESP sequencer.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        ops_d       = ops_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        done_cnt_d  = done_cnt_q;
        gnt_take_s  = 1'b0;
        case (state_q)
            IDLE: begin
                // A flush in IDLE only suppresses this cycle's grant.
                if (gnt_found_s && !flush) begin
                    gnt_take_s = 1'b1;
                    ops_d      = bus.req_data[3*gnt_idx_s +: 3];
                    rsp_id_d   = gnt_idx_s;
                    rr_ptr_d   = (gnt_idx_s == IDW'(N-1)) ? '0 : gnt_idx_s + IDW'(1);
                    cnt_d      = SW'(CONE_LAT-1);
                    state_d    = SETTLE;
                end else begin
                    state_d = IDLE;
                end
            end
            SETTLE: begin
                if (flush) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end else if (cnt_q == '0) begin
                    rsp_data_d  = cone_y;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - SW'(1);
                end
            end
            RESP: begin
                // Flush beats a simultaneous handshake: the result is dropped uncounted.
                if (flush) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end else if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    done_cnt_d  = done_cnt_q + CNTW'(1);
                    state_d     = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
        cone_en_d = (state_d == SETTLE);
        busy_d    = (state_d != IDLE);
    end

    // State and datapath registers; operands are never cleared outside reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            ops_q       <= 3'b000;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= 1'b0;
            done_cnt_q  <= '0;
            cone_en_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            ops_q       <= ops_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            done_cnt_q  <= done_cnt_d;
            cone_en_q   <= cone_en_d;
            busy_q      <= busy_d;
        end
    end

    // One-hot acceptance strobe, held low throughout reset.
    assign req_ready_s   = gnt_take_s ? (N'(1) << gnt_idx_s) : '0;
    assign bus.req_ready = req_ready_s & {N{rst_n}};

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign cone_a        = ops_q[0];
    assign cone_b        = ops_q[1];
    assign cone_c        = ops_q[2];
    assign cone_en       = cone_en_q;
    assign busy          = busy_q;
    assign done_cnt      = done_cnt_q;
endmodule

// File: tb/tb_cone_eval_sched.sv
// Scoreboard bench for cone_eval_sched: DUT A (CONE_LAT=2) covers grant, stall,
// flush and reset behaviour; DUT B (CONE_LAT=3) drives a late-settling cone.
module tb_cone_eval_sched;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush_a = 1'b0;
    logic flush_b = 1'b0;
    logic ca, cb, cc, ya, ena, busy_a;
    logic ba, bb, bc, yb, enb, busy_b;
    logic [15:0] done_a, done_b;
    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int rr_m = 0;
    int hs_cnt = 0;
    int settle_b = 0;
    int mon_g;
    logic [2:0] mon_e;
    logic [2:0] sb[$];
    int glog[$];
    int gcyc[$];

    cone_eval_if #(.N(4), .IDW(2)) ifa ();
    cone_eval_if #(.N(4), .IDW(2)) ifb ();

    cone_eval_sched #(.N(4), .IDW(2), .CONE_LAT(2), .CNTW(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush_a), .bus(ifa),
        .cone_a(ca), .cone_b(cb), .cone_c(cc), .cone_y(ya),
        .cone_en(ena), .busy(busy_a), .done_cnt(done_a));

    cone_eval_sched #(.N(4), .IDW(2), .CONE_LAT(3), .CNTW(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush_b), .bus(ifb),
        .cone_a(ba), .cone_b(bb), .cone_c(bc), .cone_y(yb),
        .cone_en(enb), .busy(busy_b), .done_cnt(done_b));

    always #5 clk = ~clk;

    // Reference cone function on {c,b,a}.
    function automatic logic cone_f(input logic [2:0] v);
        return v[0] ^ (v[1] & v[2]);
    endfunction

    // Expected round-robin winner, -1 when nothing is valid.
    function automatic int exp_grant(input logic [3:0] v, input int rr);
        for (int k = 0; k < 4; k++) begin
            if (v[(rr + k) % 4]) return (rr + k) % 4;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // DUT A cone is ideal; DUT B output is wrong for the first two settle cycles.
    assign ya = cone_f({cc, cb, ca});
    assign yb = cone_f({bc, bb, ba}) ^ (enb && (settle_b < 2));

    always @(posedge clk) begin
        cyc <= cyc + 1;
        settle_b <= enb ? settle_b + 1 : 0;
    end

    // Scoreboard monitor for DUT A: push at grant, pop and compare at handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_req_ready", 32'(ifa.req_ready), 32'd0);
        end else begin
            if (ifa.req_ready != 4'b0000) begin
                mon_g = exp_grant(ifa.req_valid, rr_m);
                chk("grant_onehot", 32'(ifa.req_ready), (mon_g < 0) ? 32'd0 : (32'd1 << mon_g));
                if (mon_g >= 0) begin
                    sb.push_back({mon_g[1:0], cone_f(ifa.req_data[3*mon_g +: 3])});
                    rr_m = (mon_g + 1) % 4;
                    glog.push_back(mon_g);
                    gcyc.push_back(cyc);
                end
            end
            if (ifa.rsp_valid && ifa.rsp_ready && !flush_a) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("rsp_id", 32'(ifa.rsp_id), 32'(mon_e[2:1]));
                    chk("rsp_data", 32'(ifa.rsp_data), 32'(mon_e[0]));
                    hs_cnt++;
                end
            end
        end
    end

    task automatic wait_ready_a();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ifa.req_ready == 4'b0000 && n < 12);
        if (ifa.req_ready == 4'b0000) chk("timeout_req_ready", 32'd0, 32'd1);
    endtask

    task automatic wait_rsp_a();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ifa.rsp_valid && n < 12);
        if (!ifa.rsp_valid) chk("timeout_rsp_valid", 32'd0, 32'd1);
    endtask

    task automatic drain_a();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    // Drive one request vector until accepted, then drop valid.
    task automatic issue_a(input logic [3:0] v, input logic [11:0] d);
        @(posedge clk); #1;
        ifa.req_valid = v;
        ifa.req_data  = d;
        wait_ready_a();
        @(posedge clk); #1;
        ifa.req_valid = 4'b0000;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "bench did not complete");
    end

    initial begin
        logic [2:0] e3;
        logic [2:0] dlist[2];
        int n;
        ifa.req_valid = 4'b1111; ifa.req_data = 12'hFFF; ifa.rsp_ready = 1'b1;
        ifb.req_valid = 4'b0000; ifb.req_data = 12'h000; ifb.rsp_ready = 1'b1;

        // Reset values, with requests pending that must not be accepted.
        #12;
        chk("rst_rsp_valid", 32'(ifa.rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(ifa.rsp_id), 32'd0);
        chk("rst_rsp_data", 32'(ifa.rsp_data), 32'd0);
        chk("rst_ops", 32'({cc, cb, ca}), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_ready", 32'(ifa.req_ready), 32'd0);
        @(posedge clk); #1;
        ifa.req_valid = 4'b0000;
        rst_n = 1'b1;

        // Test 1: single request from requester 2 with {c,b,a}=101.
        @(posedge clk); #1;
        ifa.req_valid = 4'b0100;
        ifa.req_data  = 12'h140;
        @(negedge clk);
        chk("t1_req_ready", 32'(ifa.req_ready), 32'h4);
        @(posedge clk); #1;
        ifa.req_valid = 4'b0000;
        @(negedge clk);
        chk("t1_ops_c1", 32'({cc, cb, ca}), 32'h5);
        chk("t1_cone_en", 32'(ena), 32'd1);
        chk("t1_busy", 32'(busy_a), 32'd1);
        @(negedge clk);
        chk("t1_ops_c2", 32'({cc, cb, ca}), 32'h5);
        chk("t1_no_rsp_yet", 32'(ifa.rsp_valid), 32'd0);
        @(negedge clk);
        chk("t1_rsp_valid", 32'(ifa.rsp_valid), 32'd1);
        chk("t1_cone_en_off", 32'(ena), 32'd0);
        @(negedge clk);
        chk("t1_done", 32'(done_a), 32'd1);
        chk("t1_idle", 32'(busy_a), 32'd0);

        // Test 3: response stalled; outputs stable and no new grant.
        ifa.rsp_ready = 1'b0;
        e3 = 3'b011;
        issue_a(4'b0001, {9'd0, e3});
        ifa.req_valid = 4'b1110;
        wait_rsp_a();
        for (int i = 0; i < 6; i++) begin
            chk("t3_hold_valid", 32'(ifa.rsp_valid), 32'd1);
            chk("t3_hold_id", 32'(ifa.rsp_id), 32'd0);
            chk("t3_hold_data", 32'(ifa.rsp_data), 32'(cone_f(e3)));
            chk("t3_no_grant", 32'(ifa.req_ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        ifa.rsp_ready = 1'b1;
        ifa.req_valid = 4'b0000;
        drain_a();
        chk("t3_done", 32'(done_a), 32'd2);

        // Test 4: flush in the second SETTLE cycle drops the operation.
        issue_a(4'b0010, 12'h038);
        @(posedge clk); #1;
        flush_a = 1'b1;
        @(posedge clk); #1;
        flush_a = 1'b0;
        if (sb.size() != 0) void'(sb.pop_front());
        @(negedge clk);
        chk("t4_busy", 32'(busy_a), 32'd0);
        chk("t4_cone_en", 32'(ena), 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("t4_no_rsp", 32'(ifa.rsp_valid), 32'd0);
            @(negedge clk);
        end
        chk("t4_done_kept", 32'(done_a), 32'd2);
        glog.delete();
        issue_a(4'b1111, 12'h5A3);
        chk("t4_rr_kept", 32'(glog[0]), 32'd2);
        drain_a();
        chk("t4_done", 32'(done_a), 32'd3);

        // Flush in IDLE suppresses the grant for that cycle.
        @(posedge clk); #1;
        ifa.req_valid = 4'b0001;
        ifa.req_data  = 12'h004;
        flush_a = 1'b1;
        @(negedge clk);
        chk("idle_flush_no_grant", 32'(ifa.req_ready), 32'd0);
        @(posedge clk); #1;
        flush_a = 1'b0;
        @(negedge clk);
        chk("idle_flush_then_grant", 32'(ifa.req_ready), 32'd1);
        @(posedge clk); #1;
        ifa.req_valid = 4'b0000;
        drain_a();
        chk("idle_flush_done", 32'(done_a), 32'd4);

        // Test 5: asynchronous reset while a response is pending.
        ifa.rsp_ready = 1'b0;
        issue_a(4'b1000, 12'hFFF);
        wait_rsp_a();
        @(posedge clk); #3;
        rst_n = 1'b0;
        ifa.req_valid = 4'b1111;
        #1;
        chk("t5_rsp_valid", 32'(ifa.rsp_valid), 32'd0);
        chk("t5_ops", 32'({cc, cb, ca}), 32'd0);
        chk("t5_done", 32'(done_a), 32'd0);
        chk("t5_busy", 32'(busy_a), 32'd0);
        chk("t5_ready", 32'(ifa.req_ready), 32'd0);
        sb.delete();
        rr_m = 0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        ifa.req_valid = 4'b0000;
        ifa.rsp_ready = 1'b1;
        rst_n = 1'b1;

        // Test 2: all requesters valid from reset; fair rotation and spacing.
        glog.delete();
        gcyc.delete();
        @(posedge clk); #1;
        ifa.req_data  = 12'($urandom);
        ifa.req_valid = 4'b1111;
        n = 0;
        while (glog.size() < 5 && n < 60) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        ifa.req_valid = 4'b0000;
        chk("t2_grant_count", 32'(glog.size()), 32'd5);
        if (glog.size() >= 5) begin
            for (int i = 0; i < 5; i++) chk("t2_order", 32'(glog[i]), 32'(i % 4));
            for (int i = 1; i < 5; i++) chk("t2_spacing", 32'(gcyc[i] - gcyc[i-1]), 32'd4);
        end
        drain_a();
        chk("t2_done", 32'(done_a), 32'd5);
        chk("t2_hs_vs_done", 32'(done_a), 32'(hs_cnt - 4));

        // Test 6: CONE_LAT=3 with a cone that only settles in the third cycle.
        dlist[0] = 3'b011;
        dlist[1] = 3'b100;
        for (int t = 0; t < 2; t++) begin
            @(posedge clk); #1;
            ifb.req_valid = 4'b0001;
            ifb.req_data  = {9'd0, dlist[t]};
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (ifb.req_ready == 4'b0000 && n < 12);
            chk("t6_grant", 32'(ifb.req_ready), 32'd1);
            @(posedge clk); #1;
            ifb.req_valid = 4'b0000;
            n = 0;
            do begin
                @(negedge clk);
                n++;
                if (enb) chk("t6_ops_stable", 32'({bc, bb, ba}), 32'(dlist[t]));
            end while (!ifb.rsp_valid && n < 12);
            chk("t6_latency", 32'(n), 32'd4);
            chk("t6_rsp_data", 32'(ifb.rsp_data), 32'(cone_f(dlist[t])));
            chk("t6_rsp_id", 32'(ifb.rsp_id), 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("t6_done", 32'(done_b), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
